// File: rtl/lfsr_block_stream.sv
// Streams a TOTAL_BITS random number as NUM_BLOCKS words, least-significant word first, from a Galois LFSR or constant patterns.
// Define LFSR_FORCE_ODD_TOP_EN to force an odd, full-width number in LFSR mode.
module lfsr_block_stream #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    TOTAL_BITS = 4096,
  parameter logic [WORD_WIDTH-1:0] POLY       = 32'h80200003,
  parameter logic [WORD_WIDTH-1:0] SEED       = 32'h00000001,
  localparam int                   NUM_BLOCKS = TOTAL_BITS / WORD_WIDTH,
  localparam int                   IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  trigger_in,
  input  logic [1:0]            mode_in,
  input  logic [WORD_WIDTH-1:0] seed_in,
  input  logic                  seed_valid_in,
  input  logic                  ready_in,
  output logic [WORD_WIDTH-1:0] rand_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic [IDX_W-1:0]      block_idx_out,
  output logic                  busy_out
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_ONE  = 2'd1;
  localparam logic [1:0] MODE_ZERO = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  logic [0:0]            state_reg, state_next;
  logic [WORD_WIDTH-1:0] lfsr_reg, lfsr_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [1:0]            mode_reg, mode_next;

  logic                  streaming;
  logic                  at_last;
  logic                  accept;
  logic [WORD_WIDTH-1:0] lfsr_stepped;

  assign streaming    = (state_reg == ST_STREAM);
  assign at_last      = (idx_reg == LAST_IDX);
  assign accept       = streaming && ready_in;
  assign lfsr_stepped = {1'b0, lfsr_reg[WORD_WIDTH-1:1]} ^ (lfsr_reg[0] ? POLY : '0);

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    idx_next   = idx_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_IDLE: begin
        // A zero seed would lock the LFSR up, so it is replaced by SEED.
        if (seed_valid_in)
          lfsr_next = (seed_in == '0) ? SEED : seed_in;
        if (trigger_in) begin
          state_next = ST_STREAM;
          idx_next   = '0;
          mode_next  = (mode_in == 2'd3) ? MODE_LFSR : mode_in;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (mode_reg == MODE_LFSR)
            lfsr_next = lfsr_stepped;
          if (at_last) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= ST_IDLE;
      lfsr_reg  <= SEED;
      idx_reg   <= '0;
      mode_reg  <= MODE_LFSR;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      idx_reg   <= idx_next;
      mode_reg  <= mode_next;
    end
  end

  // Output word is a pure decode of registered state, so it holds under backpressure.
  logic [WORD_WIDTH-1:0] word_next;
  always_comb begin
    word_next = '0;
    if (streaming) begin
      case (mode_reg)
        MODE_LFSR: begin
          word_next = lfsr_reg;
`ifdef LFSR_FORCE_ODD_TOP_EN
          if (idx_reg == '0)
            word_next[0] = 1'b1;
          if (at_last)
            word_next[WORD_WIDTH-1] = 1'b1;
`endif
        end
        MODE_ONE:  word_next = (idx_reg == '0) ? WORD_WIDTH'(1) : '0;
        MODE_ZERO: word_next = '0;
        default:   word_next = '0;
      endcase
    end
  end

  assign rand_out      = word_next;
  assign valid_out     = streaming;
  assign busy_out      = streaming;
  assign last_out      = streaming && at_last;
  assign block_idx_out = idx_reg;

endmodule

// File: tb/tb_lfsr_block_stream.sv
// Scoreboard bench for lfsr_block_stream: expected words are queued at each trigger and compared as the DUT emits them.
module tb_lfsr_block_stream;

  localparam int NB = 128;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        trigger_in;
  logic [1:0]  mode_in;
  logic [31:0] seed_in;
  logic        seed_valid_in;
  logic        ready_in;
  logic [31:0] rand_out;
  logic        valid_out;
  logic        last_out;
  logic [6:0]  block_idx_out;
  logic        busy_out;

  always #5 clk_in = ~clk_in;

  lfsr_block_stream dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .trigger_in    (trigger_in),
    .mode_in       (mode_in),
    .seed_in       (seed_in),
    .seed_valid_in (seed_valid_in),
    .ready_in      (ready_in),
    .rand_out      (rand_out),
    .valid_out     (valid_out),
    .last_out      (last_out),
    .block_idx_out (block_idx_out),
    .busy_out      (busy_out)
  );

  typedef struct {
    logic [31:0] word;
    logic [6:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_lfsr;
  int          checks = 0;
  int          errors = 0;
  int          stream_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic b;
    b = s[0];
    s = s >> 1;
    if (b) s = s ^ 32'h80200003;
    return s;
  endfunction

  // Queue the whole expected stream at the moment the trigger is driven.
  task automatic push_stream(input logic [1:0] m);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.idx = 7'(i);
      if (m == 2'd1)       e.word = (i == 0) ? 32'd1 : 32'd0;
      else if (m == 2'd2)  e.word = 32'd0;
      else begin
        e.word = model_lfsr;
`ifdef LFSR_FORCE_ODD_TOP_EN
        if (i == 0)      e.word[0]  = 1'b1;
        if (i == NB - 1) e.word[31] = 1'b1;
`endif
        model_lfsr = lfsr_step(model_lfsr);
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_stream(input logic [1:0] m, input bit stall, input bit seed_with_trig,
                            input logic [31:0] seed, input bit inject, input logic [31:0] first_word);
    int cyc;
    int accepts;
    @(negedge clk_in);
    mode_in    = m;
    trigger_in = 1'b1;
    if (seed_with_trig) begin
      seed_in       = seed;
      seed_valid_in = 1'b1;
      model_lfsr    = (seed == 32'd0) ? 32'd1 : seed;
    end
    check("valid_before_trigger", 32'(valid_out), 32'd0);
    push_stream(m);
    @(negedge clk_in);
    trigger_in    = 1'b0;
    seed_valid_in = 1'b0;
    mode_in       = m ^ 2'd1;
    check("valid_latency", 32'(valid_out), 32'd1);
    check("busy_latency", 32'(busy_out), 32'd1);
    check("first_word", rand_out, first_word);
    cyc     = 0;
    accepts = 0;
    while (sb.size() > 0 && cyc < 4000) begin
      ready_in = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      trigger_in    = inject && (cyc == 10);
      seed_valid_in = inject && (cyc == 10);
      seed_in       = 32'h12345678;
      if (!valid_out) begin
        check("valid_dropped_early", 32'(valid_out), 32'd1);
        break;
      end
      check("rand_out", rand_out, sb[0].word);
      check("block_idx", 32'(block_idx_out), 32'(sb[0].idx));
      check("last_out", 32'(last_out), 32'(sb[0].idx == 7'(NB - 1)));
      if (ready_in) begin
        void'(sb.pop_front());
        accepts++;
      end
      @(negedge clk_in);
      cyc++;
    end
    trigger_in    = 1'b0;
    seed_valid_in = 1'b0;
    check("stream_complete_cycles", 32'(sb.size()), 32'd0);
    check("accept_count", 32'(accepts), 32'(NB));
    check("valid_after_stream", 32'(valid_out), 32'd0);
    check("busy_after_stream", 32'(busy_out), 32'd0);
    check("last_after_stream", 32'(last_out), 32'd0);
    sb.delete();
    stream_no++;
    $display("stream %0d mode=%0d stall=%0d seed_trig=%0d inject=%0d accepts=%0d cycles=%0d errors=%0d",
             stream_no, m, stall, seed_with_trig, inject, accepts, cyc, errors);
  endtask

  initial begin
    int cyc;
    rst_n_in      = 1'b0;
    trigger_in    = 1'b0;
    mode_in       = 2'd0;
    seed_in       = 32'd0;
    seed_valid_in = 1'b0;
    ready_in      = 1'b1;
    repeat (2) @(negedge clk_in);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_last", 32'(last_out), 32'd0);
    check("reset_idx", 32'(block_idx_out), 32'd0);
    check("reset_rand", rand_out, 32'd0);
    rst_n_in   = 1'b1;
    model_lfsr = 32'h00000001;

    // Constant-one stream first, then LFSR must still start from the reset seed.
    run_stream(2'd1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1);
    run_stream(2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000001);
    run_stream(2'd0, 1'b1, 1'b0, 32'd0, 1'b0, model_lfsr);
    run_stream(2'd2, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    run_stream(2'd3, 1'b1, 1'b0, 32'd0, 1'b0, model_lfsr);

    // Zero seed loaded in IDLE falls back to the reset seed.
    @(negedge clk_in);
    seed_in       = 32'd0;
    seed_valid_in = 1'b1;
    @(negedge clk_in);
    seed_valid_in = 1'b0;
    model_lfsr    = 32'h00000001;
    run_stream(2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000001);

    run_stream(2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    run_stream(2'd0, 1'b1, 1'b0, 32'd0, 1'b1, model_lfsr);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk_in);
    mode_in    = 2'd0;
    trigger_in = 1'b1;
    ready_in   = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    cyc = 0;
    while (block_idx_out != 7'd50 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
    end
    check("reach_idx50", 32'(block_idx_out), 32'd50);
    rst_n_in = 1'b0;
    #1;
    check("midreset_valid", 32'(valid_out), 32'd0);
    check("midreset_busy", 32'(busy_out), 32'd0);
    check("midreset_last", 32'(last_out), 32'd0);
    check("midreset_idx", 32'(block_idx_out), 32'd0);
    check("midreset_rand", rand_out, 32'd0);
    @(negedge clk_in);
    rst_n_in   = 1'b1;
    model_lfsr = 32'h00000001;
    run_stream(2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000001);

`ifdef LFSR_FORCE_ODD_TOP_EN
    @(negedge clk_in);
    seed_in       = 32'h00000002;
    seed_valid_in = 1'b1;
    @(negedge clk_in);
    seed_valid_in = 1'b0;
    model_lfsr    = 32'h00000002;
    run_stream(2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000003);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_block_stream.md
Name: lfsr_block_stream

Overview:
- Parametrised generator of a TOTAL_BITS-wide random big number.
- The number is streamed least-significant word first as NUM_BLOCKS words of WORD_WIDTH bits, one stream per trigger.
- Feeds the modular-arithmetic datapath (e.g. Paillier blinding-factor generation) through a valid/ready/last word interface.
- Modes: a real Galois LFSR stream, or the deterministic constants 1 and 0 for datapath bring-up.

Parameters:
- WORD_WIDTH, 32, bits per streamed word and LFSR register width.
- TOTAL_BITS, 4096, bits per big number; must be a multiple of WORD_WIDTH.
- NUM_BLOCKS, TOTAL_BITS/WORD_WIDTH, derived (localparam), words per stream.
- POLY, 32'h80200003, Galois feedback mask (taps 32,22,2,1), WORD_WIDTH wide.
- SEED, 32'h00000001, reset seed and substitute for an all-zero loaded seed.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  asynchronous active-low reset.
- trigger_in  input  1  start one stream.
- mode_in  input  2  0=LFSR, 1=constant one, 2=constant zero, 3=reserved (treated as 0). Sampled at the accepted trigger.
- seed_in  input  WORD_WIDTH  new LFSR seed.
- seed_valid_in  input  1  load seed_in.
- ready_in  input  1  downstream accepts the current word.
- rand_out  output  WORD_WIDTH  current word.
- valid_out  output  1  rand_out holds a word of the stream.
- last_out  output  1  current word is block NUM_BLOCKS-1.
- block_idx_out  output  $clog2(NUM_BLOCKS)  index of the current word.
- busy_out  output  1  stream in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, lfsr=SEED, block index=0, mode register=0.
  - valid_out=0, last_out=0, busy_out=0, block_idx_out=0, rand_out=0.
- State machine, two states:
  - IDLE -> STREAM when trigger_in=1. busy_out=1 and valid_out=1 from the next cycle (1-cycle latency). Index=0.
  - STREAM -> IDLE when the word with index NUM_BLOCKS-1 is accepted (valid_out&&ready_in). valid_out=0 the following cycle.
- Accept = valid_out&&ready_in.
  - On accept the index increments.
  - In LFSR mode only, the LFSR steps: b=s[0]; s=s>>1; if b, s^=POLY.
- Backpressure: while valid_out=1 and ready_in=0, rand_out, block_idx_out, last_out and the LFSR hold.
- rand_out by mode:
  - LFSR: current LFSR state.
  - Constant one: 1 at index 0, 0 otherwise.
  - Constant zero: 0.
  - Outside STREAM: 0.
- LFSR state persists across streams; a new stream continues the sequence and is not reseeded.
- Seed load:
  - seed_valid_in in IDLE loads seed_in next cycle.
  - An all-zero seed_in loads SEED instead (lock-up avoidance).
  - seed_valid_in during STREAM is ignored.
- Simultaneous seed_valid_in and trigger_in in IDLE: the seed loads and the first word is the new seed.
- trigger_in during STREAM is ignored; no restart, no queueing.
- mode_in changes during STREAM have no effect.
- Reset mid-stream aborts immediately; no partial-stream completion.
- last_out = (state==STREAM) && (index==NUM_BLOCKS-1).
- Exactly NUM_BLOCKS accepts per trigger.

Optional Feature:
- Macro: LFSR_FORCE_ODD_TOP_EN.
- Defined: in LFSR mode, bit 0 of word 0 and bit WORD_WIDTH-1 of word NUM_BLOCKS-1 are forced to 1 on rand_out only. The LFSR state is unaffected, so the output is an odd number of exactly TOTAL_BITS significant bits.
- Undefined: raw LFSR words are output unmodified.
- Constant modes are unaffected either way.

Test Plan:
- Reset, seed_valid_in=0, mode=0, trigger, ready_in=1 -> valid_out rises 1 cycle after trigger; words 0,1,2 = 0x00000001, 0x80200003, 0xC0300002; last_out only at index 127; valid_out=0 after 128 accepts.
- mode=1, trigger, ready_in=1 -> word 0 = 1, words 1..127 = 0, 128 words total; LFSR state still 0x00000001 afterwards.
- LFSR stream with ready_in toggled 1,0,0,1 -> rand_out and block_idx_out hold during stalls; sequence identical to the no-stall run.
- Load seed 0 in IDLE then trigger -> word 0 = 0x00000001. Load 0xDEADBEEF with trigger in the same cycle -> word 0 = 0xDEADBEEF. Trigger and seed_valid_in pulsed mid-stream -> ignored, still 128 words.
- Assert rst_n_in at index 50 -> valid_out, busy_out, last_out = 0 immediately; next trigger restarts at index 0 with word 0x00000001.
- LFSR_FORCE_ODD_TOP_EN defined, seed 0x00000002 -> word 0 = 0x00000003; word 127 has bit 31 = 1.
